// File: rtl/rmac_pipe.sv
// rmac_pipe: pipelined multi-lane multiply-accumulate for sign-magnitude
// fixed-point vectors. Each accepted beat multiplies LANES w/x pairs; the
// registered products are reduced by a saturating adder tree and folded into
// the accumulator on the following edge. The result is held in OUT until the
// consumer takes it, with optional ReLU clamping and a sticky saturation flag.
module rmac_pipe #(
  parameter int N        = 32,
  parameter int INTBITS  = 12,
  parameter int FRACBITS = 20,
  parameter int LANES    = 4,
  parameter int LW       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [LW-1:0]      len,
  input  logic               relu_en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*N-1:0] w,
  input  logic [LANES*N-1:0] x,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       sum,
  output logic               ovf,
  output logic               busy
);

  // Magnitude width follows the Q format: one bit of the word is the sign.
  localparam int           M       = INTBITS + FRACBITS - 1;
  localparam logic [M-1:0] MAG_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  // Sign-magnitude multiply: {sat, sign, magnitude}. Zero results are positive.
  function automatic logic [N:0] sm_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*M-1:0] full;
    logic [2*M-1:0] shifted;
    logic           sat;
    logic [M-1:0]   mag;
    // NOTE: blocking (=) is right inside functions; these locals are
    // combinational temporaries evaluated in order, not registers.
    full    = {{M{1'b0}}, a[M-1:0]} * {{M{1'b0}}, b[M-1:0]};
    shifted = full >> FRACBITS;
    sat     = |shifted[2*M-1:M];
    mag     = sat ? MAG_MAX : shifted[M-1:0];
    return {sat, (a[N-1] ^ b[N-1]) & (|mag), mag};
  endfunction

  // Sign-magnitude add with saturation: {sat, sign, magnitude}.
  function automatic logic [N:0] sm_add(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [M:0]   wide;
    logic [M-1:0] mag;
    logic         sgn;
    logic         sat;
    sat = 1'b0;
    if (a[N-1] == b[N-1]) begin
      wide = {1'b0, a[M-1:0]} + {1'b0, b[M-1:0]};
      sat  = wide[M];
      mag  = sat ? MAG_MAX : wide[M-1:0];
      sgn  = a[N-1];
    end else if (a[M-1:0] >= b[M-1:0]) begin
      mag = a[M-1:0] - b[M-1:0];
      sgn = a[N-1];
    end else begin
      mag = b[M-1:0] - a[M-1:0];
      sgn = b[N-1];
    end
    // Cancellation must never leave a negative zero behind.
    if (mag == '0) sgn = 1'b0;
    return {sat, sgn, mag};
  endfunction

  // Heap-ordered binary reduction: node i sums children 2i+1 and 2i+2,
  // leaves hold the lane products, node 0 is the tree result.
  function automatic logic [N:0] tree_sum(input logic [LANES*N-1:0] p);
    logic [N-1:0] node [2*LANES-1];
    logic [N:0]   r;
    logic         o;
    o = 1'b0;
    r = '0;
    for (int k = 0; k < LANES; k++) node[LANES-1+k] = p[k*N +: N];
    for (int i = LANES - 2; i >= 0; i--) begin
      r       = sm_add(node[2*i+1], node[2*i+2]);
      node[i] = r[N-1:0];
      o       = o | r[N];
    end
    return {o, node[0]};
  endfunction

  state_t             state_q;
  logic [LW-1:0]      cnt_q;
  logic               relu_q;
  logic [N-1:0]       acc_q;
  logic               job_ovf_q;
  logic [LANES*N-1:0] prod_q;
  logic               prod_vld_q;

  logic [LANES*N-1:0] prod_d;
  logic               prod_ovf_d;
  logic [N:0]         tree_r;
  logic [N:0]         acc_r;
  logic               accept;
  logic               job_ovf_next;

  // Lane multipliers feeding the product register.
  always_comb begin
    logic [N:0] mr;
    // NOTE: every always_comb output gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    prod_d     = '0;
    prod_ovf_d = 1'b0;
    mr         = '0;
    for (int k = 0; k < LANES; k++) begin
      mr                 = sm_mul(w[k*N +: N], x[k*N +: N]);
      prod_d[k*N +: N]   = mr[N-1:0];
      prod_ovf_d         = prod_ovf_d | mr[N];
    end
  end

  assign tree_r       = tree_sum(prod_q);
  assign acc_r        = sm_add(acc_q, tree_r[N-1:0]);
  assign accept       = (state_q == ACC) && in_valid;
  assign job_ovf_next = job_ovf_q | (accept & prod_ovf_d) | (prod_vld_q & (tree_r[N] | acc_r[N]));

  // Control FSM, product pipeline stage and accumulator with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      relu_q     <= 1'b0;
      acc_q      <= '0;
      job_ovf_q  <= 1'b0;
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      sum        <= '0;
      ovf        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // NOTE: non-blocking (<=) for all state so every register here sees
      // the pre-edge values regardless of statement order.
      if (prod_vld_q) acc_q <= acc_r[N-1:0];
      prod_vld_q <= 1'b0;
      job_ovf_q  <= job_ovf_next;

      unique case (state_q)
        IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            relu_q    <= relu_en;
            cnt_q     <= len;
            acc_q     <= '0;
            job_ovf_q <= 1'b0;
            if (len == '0) begin
              state_q   <= OUT;
              sum       <= '0;
              ovf       <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              state_q  <= ACC;
              in_ready <= 1'b1;
            end
          end
        end
        ACC: begin
          if (in_valid) begin
            prod_q     <= prod_d;
            prod_vld_q <= 1'b1;
            cnt_q      <= cnt_q - LW'(1);
            if (cnt_q == LW'(1)) begin
              state_q  <= DRAIN;
              in_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // The last beat's products are being folded in on this very edge.
          state_q   <= OUT;
          out_valid <= 1'b1;
          sum       <= (relu_q && acc_r[N-1]) ? '0 : acc_r[N-1:0];
          ovf       <= job_ovf_next;
        end
        OUT: begin
          if (out_ready) begin
            state_q   <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rmac_pipe.sv
// tb_rmac_pipe: directed and randomized jobs for rmac_pipe, checked against an
// integer-domain reference model (values in LSB units, clamp to +/-(2^31-1)).
module tb_rmac_pipe;

  localparam int N        = 32;
  localparam int LANES    = 4;
  localparam int LW       = 8;
  localparam int FRACBITS = 20;
  localparam longint MAXM = (64'sd1 <<< (N - 1)) - 1;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic [LW-1:0]      len = '0;
  logic               relu_en = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [LANES*N-1:0] w = '0;
  logic [LANES*N-1:0] x = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [N-1:0]       sum;
  logic               ovf;
  logic               busy;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  logic [LANES*N-1:0] wq[$];
  logic [LANES*N-1:0] xq[$];

  always #5 clk = ~clk;

  rmac_pipe #(
    .N(N), .INTBITS(12), .FRACBITS(FRACBITS), .LANES(LANES), .LW(LW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .relu_en(relu_en),
    .in_valid(in_valid), .in_ready(in_ready), .w(w), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .ovf(ovf), .busy(busy)
  );

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic longint clampv(input longint v, inout bit o);
    if (v > MAXM) begin o = 1'b1; return MAXM; end
    if (v < -MAXM) begin o = 1'b1; return -MAXM; end
    return v;
  endfunction

  // Reference: exact integer products truncated by 2^FRACBITS, balanced pair
  // tree per beat, running total, every step clamped to the magnitude range.
  task automatic model(input int n, input bit relu, output logic [N-1:0] s, output bit o);
    longint       acc;
    longint       m;
    longint       p [LANES];
    longint       a;
    longint       b;
    logic [N-1:0] wk;
    logic [N-1:0] xk;
    acc = 0;
    o   = 1'b0;
    for (int j = 0; j < n; j++) begin
      for (int k = 0; k < LANES; k++) begin
        wk   = wq[j][k*N +: N];
        xk   = xq[j][k*N +: N];
        m    = (longint'(wk[N-2:0]) * longint'(xk[N-2:0])) >>> FRACBITS;
        m    = clampv(m, o);
        p[k] = (wk[N-1] ^ xk[N-1]) ? -m : m;
      end
      a   = clampv(p[0] + p[1], o);
      b   = clampv(p[2] + p[3], o);
      acc = clampv(acc + clampv(a + b, o), o);
    end
    if (relu && acc < 0) acc = 0;
    s = (acc < 0) ? {1'b1, 31'(-acc)} : {1'b0, 31'(acc)};
  endtask

  function automatic logic [N-1:0] rand_word();
    if ($urandom_range(0, 7) == 0) return $urandom;
    return {1'($urandom_range(0, 1)), 31'($urandom_range(0, 32'h0100_0000))};
  endfunction

  // One complete job: start, feed wq/xq (pattern pat for the first plen
  // cycles, then random gaps or gap-free), stall the consumer, hand off.
  task automatic run_job(input string tag, input int n, input bit relu,
                         input logic [15:0] pat, input int plen, input bit rgaps,
                         input int stall, output logic [N-1:0] got_sum, output logic got_ovf);
    logic [N-1:0] exp_s;
    bit           exp_o;
    int           sent;
    int           cyc;
    bit           ready_ok;
    bit           stable_ok;
    model(n, relu, exp_s, exp_o);
    @(negedge clk);
    start = 1'b1; len = LW'(n); relu_en = relu;
    @(negedge clk);
    start = 1'b0; len = LW'($urandom); relu_en = ~relu;
    if (n > 0) begin
      sent = 0; cyc = 0; ready_ok = 1'b1;
      while (sent < n && cyc < 200) begin
        if (in_ready !== 1'b1) ready_ok = 1'b0;
        if (cyc < plen) in_valid = pat[cyc];
        else in_valid = rgaps ? 1'($urandom_range(0, 1)) : 1'b1;
        if (in_valid) begin
          w = wq[sent]; x = xq[sent];
        end else begin
          w = {$urandom, $urandom, $urandom, $urandom};
          x = {$urandom, $urandom, $urandom, $urandom};
        end
        @(negedge clk);
        if (in_valid) sent++;
        cyc++;
      end
      in_valid = 1'b0;
      w = {$urandom, $urandom, $urandom, $urandom};
      check({tag, " in_ready during ACC"}, 64'(ready_ok), 64'd1);
      check({tag, " beats within budget"}, 64'(sent), 64'(n));
      check({tag, " drain {in_ready,out_valid,busy}"}, 64'({in_ready, out_valid, busy}), 64'b001);
      @(negedge clk);
    end
    check({tag, " out_valid latency"}, 64'(out_valid), 64'd1);
    check({tag, " sum"}, 64'(sum), 64'(exp_s));
    check({tag, " ovf"}, 64'(ovf), 64'(exp_o));
    got_sum = sum;
    got_ovf = ovf;
    stable_ok = 1'b1;
    for (int i = 0; i < stall; i++) begin
      if (i == 1) begin start = 1'b1; len = LW'(2); end
      @(negedge clk);
      start = 1'b0;
      if (out_valid !== 1'b1 || sum !== exp_s || ovf !== exp_o || busy !== 1'b1) stable_ok = 1'b0;
    end
    if (stall > 0) check({tag, " held while stalled"}, 64'(stable_ok), 64'd1);
    out_ready = 1'b1; start = 1'b1; len = LW'(3);
    @(negedge clk);
    out_ready = 1'b0; start = 1'b0;
    check({tag, " idle after handoff"}, 64'({out_valid, busy, in_ready}), 64'b000);
  endtask

  initial begin
    logic [N-1:0] s1;
    logic [N-1:0] s2;
    logic         o1;
    bit           quiet;
    int           n;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("reset in_ready", 64'(in_ready), 64'd0);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset sum", 64'(sum), 64'd0);
    check("reset ovf", 64'(ovf), 64'd0);
    reset = 1'b1;

    // Basic dot product: 2 beats x 4 lanes x (1.0 * 2.0) = 16.0
    wq.delete(); xq.delete();
    repeat (2) begin wq.push_back({4{32'h0010_0000}}); xq.push_back({4{32'h0020_0000}}); end
    run_job("basic", 2, 1'b0, 16'h0, 0, 1'b0, 0, s1, o1);
    check("basic sum constant", 64'(s1), 64'h0100_0000);
    check("basic ovf constant", 64'(o1), 64'd0);

    // Negative result, with and without ReLU
    wq.delete(); xq.delete();
    wq.push_back({96'h0, 32'h0010_0000}); xq.push_back({96'h0, 32'h8030_0000});
    run_job("neg", 1, 1'b0, 16'h0, 0, 1'b0, 1, s1, o1);
    check("neg sum constant", 64'(s1), 64'h8030_0000);
    run_job("relu", 1, 1'b1, 16'h0, 0, 1'b0, 0, s1, o1);
    check("relu sum constant", 64'(s1), 64'h0);

    // Saturation then sticky flag cleared by the next job
    wq.delete(); xq.delete();
    wq.push_back({96'h0, 32'h7FF0_0000}); xq.push_back({96'h0, 32'h7FF0_0000});
    run_job("sat", 1, 1'b0, 16'h0, 0, 1'b0, 0, s1, o1);
    check("sat sum constant", 64'(s1), 64'h7FFF_FFFF);
    check("sat ovf constant", 64'(o1), 64'd1);
    wq.delete(); xq.delete();
    wq.push_back({96'h0, 32'h0010_0000}); xq.push_back({96'h0, 32'h0030_0000});
    run_job("after sat", 1, 1'b0, 16'h0, 0, 1'b0, 0, s1, o1);
    check("after sat ovf constant", 64'(o1), 64'd0);

    // Flow control: gap-free reference, then valid 1,0,0,1,1 and 5 stalled cycles
    wq.delete(); xq.delete();
    repeat (3) begin
      wq.push_back({rand_word(), rand_word(), rand_word(), rand_word()} & {4{32'h80FF_FFFF}});
      xq.push_back({rand_word(), rand_word(), rand_word(), rand_word()} & {4{32'h80FF_FFFF}});
    end
    run_job("flow ref", 3, 1'b0, 16'h0, 0, 1'b0, 0, s1, o1);
    run_job("flow gaps", 3, 1'b0, 16'h0019, 5, 1'b0, 5, s2, o1);
    check("flow gaps equals gap-free", 64'(s2), 64'(s1));

    // Reset in the middle of ACC after 1 of 3 beats
    wq.delete(); xq.delete();
    repeat (3) begin wq.push_back({4{32'h0050_0000}}); xq.push_back({4{32'h0040_0000}}); end
    @(negedge clk);
    start = 1'b1; len = LW'(3); relu_en = 1'b0;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; w = wq[0]; x = xq[0];
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort outputs cleared", 64'({in_ready, out_valid, busy, ovf}), 64'b0000);
    check("abort sum cleared", 64'(sum), 64'h0);
    @(negedge clk);
    reset = 1'b1;
    quiet = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    check("abort produces no result", 64'(quiet), 64'd1);
    wq.delete(); xq.delete();
    wq.push_back({96'h0, 32'h0020_0000}); xq.push_back({96'h0, 32'h0010_0000});
    run_job("post abort", 1, 1'b0, 16'h0, 0, 1'b0, 0, s1, o1);
    check("post abort sum constant", 64'(s1), 64'h0020_0000);

    // Cancellation to positive zero, and zero-length job
    wq.delete(); xq.delete();
    wq.push_back({96'h0, 32'h0020_0000}); xq.push_back({96'h0, 32'h0010_0000});
    wq.push_back({96'h0, 32'h0020_0000}); xq.push_back({96'h0, 32'h8010_0000});
    run_job("cancel", 2, 1'b0, 16'h0, 0, 1'b0, 0, s1, o1);
    check("cancel sum constant", 64'(s1), 64'h0);
    run_job("len0", 0, 1'b0, 16'h0, 0, 1'b0, 2, s1, o1);
    check("len0 sum constant", 64'(s1), 64'h0);

    // Randomized jobs
    for (int j = 0; j < 40; j++) begin
      n = $urandom_range(1, 6);
      wq.delete(); xq.delete();
      for (int b = 0; b < n; b++) begin
        wq.push_back({rand_word(), rand_word(), rand_word(), rand_word()});
        xq.push_back({rand_word(), rand_word(), rand_word(), rand_word()});
      end
      run_job($sformatf("rand%0d", j), n, 1'($urandom_range(0, 1)), 16'h0, 0, 1'b1,
              $urandom_range(0, 3), s1, o1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rmac_pipe.md
RMAC_PIPE -- requirements
Module: rmac_pipe

Interface
REQ-001 Parameter N, default 32: word width, sign-magnitude fixed point (bit N-1 = sign, bits N-2:0 = magnitude).
REQ-002 Parameter INTBITS, default 12: integer bits of the Q format.
REQ-003 Parameter FRACBITS, default 20: fraction bits; INTBITS+FRACBITS SHALL equal N.
REQ-004 Parameter LANES, default 4: weight/input pairs multiplied per accepted beat.
REQ-005 Parameter LW, default 8: width of the beat-count input len.
REQ-006 clk  input  1  single clock; all state changes on the rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  one-cycle request to begin a dot product; sampled only in IDLE.
REQ-009 len  input  LW  beats in the vector; captured with start.
REQ-010 relu_en  input  1  captured with start; 1 = clamp negative result to zero, 0 = pass signed result.
REQ-011 in_valid  input  1  w/x beat valid.
REQ-012 in_ready  output  1  block accepts a beat; a beat transfers when in_valid and in_ready are both 1.
REQ-013 w, x  input  LANES*N  packed lane operands; lane i at bits [i*N+N-1 : i*N].
REQ-014 out_valid  output  1  result available.
REQ-015 out_ready  input  1  consumer takes the result when out_valid and out_ready are both 1.
REQ-016 sum  output  N  result word.
REQ-017 ovf  output  1  at least one product or addition in this job saturated; valid with out_valid.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 States SHALL be IDLE, ACC, DRAIN and OUT.
REQ-020 IDLE: start=1 with len>0 captures len and relu_en, clears the accumulator and ovf, and moves to ACC.
REQ-021 IDLE: start=1 with len=0 moves directly to OUT with sum=0 and ovf=0.
REQ-022 ACC: in_ready=1; each transfer decrements the remaining count; the transfer of the last beat moves to DRAIN on the same edge.
REQ-023 in_valid low in ACC stalls the job without limit; the accumulator and count hold.
REQ-024 DRAIN lasts exactly one cycle with in_ready=0, then moves to OUT.
REQ-025 Pipeline: the edge that accepts a beat registers its LANES products; the following edge adds them into the accumulator.
REQ-026 out_valid SHALL rise on the second rising edge after the edge that accepted the last beat.
REQ-027 OUT: out_valid=1; sum and ovf SHALL be held stable until out_valid and out_ready are both 1, then the block returns to IDLE.
REQ-028 start is ignored outside IDLE, including the OUT handshake cycle.
REQ-029 Product magnitude SHALL be (|w|*|x|) >> FRACBITS, truncated; product sign SHALL be sign(w) XOR sign(x).
REQ-030 Addition SHALL use sign-magnitude rules: like signs add magnitudes; unlike signs subtract the smaller from the larger and take the sign of the larger.
REQ-031 Any magnitude above 2^(N-1)-1 SHALL saturate to 2^(N-1)-1 with sign kept, and SHALL set the sticky ovf.
REQ-032 A zero magnitude SHALL always carry sign 0; negative zero is never produced.
REQ-033 Lane products SHALL be reduced by a saturating sign-magnitude adder tree; the tree result is then added to the accumulator with saturation.
REQ-034 Final output: relu_en=1 with a negative accumulator gives sum=0; otherwise sum equals the accumulator.

Reset
REQ-035 reset low SHALL, asynchronously, force IDLE and clear the accumulator, count, pipeline registers, sum, ovf, out_valid, in_ready and busy to 0.
REQ-036 reset asserted mid-job SHALL abort the job; no out_valid is produced for it.

Verification
REQ-037 Basic dot product: LANES=4, len=2, all w=0x00100000 (1.0), all x=0x00200000 (2.0), in_valid held 1 -> sum=0x01000000 (16.0), ovf=0, out_valid 2 edges after the second beat is accepted.
REQ-038 Negative result and ReLU: lane0 w=1.0, x=0x80300000 (-3.0), other lanes 0, len=1 -> with relu_en=0, sum=0x80300000; with relu_en=1, sum=0x00000000.
REQ-039 Saturation: lane0 w=x=0x7FF00000 (2047.0), len=1 -> sum=0x7FFFFFFF, ovf=1; a following job with small operands -> ovf=0.
REQ-040 Flow control: in_valid toggles 1,0,0,1,1 over len=3, then out_ready held low 5 cycles -> result identical to the gap-free run; sum and out_valid stable while stalled; a start pulse during OUT is ignored.
REQ-041 Cancellation and zero cases: beats +2.0 then -2.0 on lane0 -> sum=0x00000000 (not 0x80000000); len=0 -> out_valid on the next edge with sum=0.
REQ-042 Reset mid-ACC after 1 of 3 beats -> all outputs 0 immediately, state IDLE; a new job afterwards gives the correct sum with no leftover contribution from the aborted job.
